// File: rtl/nway_stream_divider.sv
// nway_stream_divider
// One valid/ready input stream fanned out to NCH independent output channels.
// Every channel owns a small first-word-fall-through FIFO, so a stalled consumer
// only affects its own channel. Two split modes: broadcast (every beat goes to
// every channel) and round-robin (each beat goes to one channel in turn). With
// isolate=1 the input never stalls; beats aimed at a full channel are dropped
// and counted in that channel's saturating drop counter.
//
// Handshake: a beat moves across an interface on a rising edge where valid and
// ready are both 1. in_ready depends only on registered FIFO occupancy, the rr
// pointer, mode, isolate and rst_n -- never on out_ready -- so a pop in the same
// cycle never frees space for a push in that cycle. out_valid[i] is simply
// "channel i FIFO is non-empty" and is not gated by out_ready.
//
// The design has no control FSM; the only sequencing state is the round-robin
// pointer rr, which a bench may observe hierarchically.

module nway_stream_divider #(
   parameter int WIDTH = 16,
   parameter int NCH   = 2,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mode,
   input  logic                   isolate,
   input  logic                   clr_cnt,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic [NCH-1:0]         out_valid,
   input  logic [NCH-1:0]         out_ready,
   output logic [NCH*WIDTH-1:0]   out_data,
   output logic [NCH*CNT_W-1:0]   drop_cnt
);

   localparam int RR_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;

   localparam logic [RR_W-1:0] RR_LAST = RR_W'(NCH - 1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

   // Round-robin pointer: channel that receives the next accepted beat in split mode.
   logic [RR_W-1:0]  rr;

   // Per-channel FIFO storage and bookkeeping.
   logic [WIDTH-1:0] mem     [NCH][DEPTH];
   logic [AW-1:0]    wr_ptr  [NCH];
   logic [AW-1:0]    rd_ptr  [NCH];
   logic [CW-1:0]    count   [NCH];
   logic [CNT_W-1:0] cnt     [NCH];

   logic [NCH-1:0]   full;
   logic [NCH-1:0]   target;
   logic [NCH-1:0]   push;
   logic [NCH-1:0]   pop;
   logic [NCH-1:0]   drop;
   logic             any_full;
   logic             rr_full;
   logic             accept;

   // Occupancy flags, beat routing, and the input handshake.
   always_comb begin
      full     = '0;
      target   = '0;
      any_full = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         full[i]   = (count[i] == CNT_FULL);
         target[i] = mode ? (rr == RR_W'(i)) : 1'b1;
         any_full  = any_full | full[i];
      end
      rr_full = full[rr];

      // Held low during reset; otherwise only a lossless mode can stall the source.
      if (!rst_n) begin
         in_ready = 1'b0;
      end else if (isolate) begin
         in_ready = 1'b1;
      end else if (mode) begin
         in_ready = !rr_full;
      end else begin
         in_ready = !any_full;
      end

      accept = in_valid & in_ready;

      // "full" is start-of-cycle occupancy: a targeted full channel drops even if it pops now.
      push = '0;
      drop = '0;
      pop  = '0;
      for (int i = 0; i < NCH; i++) begin
         push[i] = accept & target[i] & !full[i];
         drop[i] = accept & target[i] &  full[i];
         pop[i]  = out_valid[i] & out_ready[i];
      end
   end

   // Output views: FIFO heads are shown only while the channel holds data.
   always_comb begin
      out_valid = '0;
      out_data  = '0;
      drop_cnt  = '0;
      for (int i = 0; i < NCH; i++) begin
         out_valid[i] = (count[i] != '0);
         if (count[i] != '0) begin
            out_data[i*WIDTH +: WIDTH] = mem[i][rd_ptr[i]];
         end
         drop_cnt[i*CNT_W +: CNT_W] = cnt[i];
      end
   end

   // FIFO pointers and occupancy; reset empties every channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (push[i]) begin
               wr_ptr[i] <= wr_ptr[i] + 1'b1;
            end
            if (pop[i]) begin
               rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
            count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
         end
      end
   end

   // FIFO storage writes; contents are invisible until count says they are valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (push[i]) begin
            mem[i][wr_ptr[i]] <= in_data;
         end
      end
   end

   // Round-robin pointer advances on every accepted beat in split mode, dropped or not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr <= '0;
      end else if (accept && mode) begin
         rr <= (rr == RR_LAST) ? '0 : rr + 1'b1;
      end
   end

   // Saturating drop counters; a clear wins over a coincident drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (clr_cnt) begin
               cnt[i] <= '0;
            end else if (drop[i] && (cnt[i] != '1)) begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

endmodule
